// File: rtl/pipe_monitor_if.sv
// pipe_monitor_if: one-cycle request/acknowledge readout port of pipe_monitor.
interface pipe_monitor_if #(parameter int CNT_W = 32);
    logic             req_i;
    logic [1:0]       sel_i;
    logic             ack_o;
    logic [CNT_W-1:0] data_o;
    modport master (output req_i, sel_i, input ack_o, data_o);
    modport slave  (input req_i, sel_i, output ack_o, data_o);
endinterface

// File: rtl/pipe_monitor.sv
// pipe_monitor: counts run cycles, load-use stalls, flushes and retires of the CPU; halts after CYCLE_LIMIT run cycles.
// Define PIPE_MONITOR_SAT_EN to make the counters saturate instead of wrapping.
module pipe_monitor #(
    parameter int CNT_W       = 32,
    parameter int CYCLE_LIMIT = 30
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          clr_i,
    input  logic          stall_i,
    input  logic          flush_i,
    input  logic          jump_i,
    input  logic          branch_i,
    input  logic          retire_i,
    pipe_monitor_if.slave rd,
    output logic          halt_o,
    output logic          running_o
);
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_cnt [4];
    logic             r_ack;
    logic [CNT_W-1:0] r_data;
    logic [3:0]       w_ev;
    logic             w_hit;
    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c);
`ifdef PIPE_MONITOR_SAT_EN
        return &c ? c : c + CNT_W'(1);
`else
        return c + CNT_W'(1);
`endif
    endfunction
    // index order matches sel_i: cycle, stall, flush, retire
    assign w_ev = {retire_i, flush_i, stall_i & ~jump_i & ~branch_i, 1'b1};
    always_comb begin
        w_hit  = (CYCLE_LIMIT != 0) && (bump(r_cnt[0]) == CNT_W'(CYCLE_LIMIT));
        w_next = clr_i            ? IDLE :
                 r_state == IDLE  ? (start_i ? RUN : IDLE) :
                 r_state == RUN   ? (w_hit ? HALT : start_i ? RUN : IDLE) :
                 HALT;
    end
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
            r_ack   <= 1'b0;
            r_data  <= '0;
            for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
        end else begin
            r_state <= w_next;
            r_ack   <= rd.req_i;
            if (rd.req_i) r_data <= r_cnt[rd.sel_i];
            for (int i = 0; i < 4; i++)
                if (clr_i) r_cnt[i] <= '0;
                else if (r_state == RUN && w_ev[i]) r_cnt[i] <= bump(r_cnt[i]);
        end
    end
    assign rd.ack_o   = r_ack;
    assign rd.data_o  = r_data;
    assign running_o  = r_state == RUN;
    assign halt_o     = r_state == HALT;
endmodule

// File: tb/tb_pipe_monitor.sv
// tb_pipe_monitor: directed and randomized checks of pipe_monitor against a counting model.
module tb_pipe_monitor;
    localparam int LIMIT = 30;
    logic clk_i = 1'b0, rst_i, start_i, clr_i, stall_i, flush_i, jump_i, branch_i, retire_i;
    logic halt_o, running_o, halt2, running2;
    int   n_cmp = 0, n_bad = 0;
    int   m_cnt [4];
    int   m_data;
    bit   m_ack, m_run, m_halt;

    pipe_monitor_if #(.CNT_W(32)) bus ();
    pipe_monitor_if #(.CNT_W(4))  bus2 ();

    pipe_monitor #(.CNT_W(32), .CYCLE_LIMIT(LIMIT)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .clr_i(clr_i), .stall_i(stall_i),
        .flush_i(flush_i), .jump_i(jump_i), .branch_i(branch_i), .retire_i(retire_i),
        .rd(bus.slave), .halt_o(halt_o), .running_o(running_o));

    pipe_monitor #(.CNT_W(4), .CYCLE_LIMIT(0)) dut4 (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .clr_i(clr_i), .stall_i(stall_i),
        .flush_i(flush_i), .jump_i(jump_i), .branch_i(branch_i), .retire_i(retire_i),
        .rd(bus2.slave), .halt_o(halt2), .running_o(running2));

    always #5 clk_i = ~clk_i;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        m_data = 0; m_ack = 0; m_run = 0; m_halt = 0;
    endtask

    // One clock edge: the model sees the same inputs the DUT samples, then we move to the falling edge.
    task automatic tick();
        @(posedge clk_i);
        m_ack = bus.req_i;
        if (bus.req_i) m_data = m_cnt[bus.sel_i];
        if (clr_i) begin
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
            m_run = 0; m_halt = 0;
        end else if (m_run) begin
            m_cnt[0] += 1;
            if (stall_i && !jump_i && !branch_i) m_cnt[1] += 1;
            if (flush_i) m_cnt[2] += 1;
            if (retire_i) m_cnt[3] += 1;
            if (m_cnt[0] == LIMIT) begin m_run = 0; m_halt = 1; end
            else if (!start_i) m_run = 0;
        end else if (!m_halt && start_i) m_run = 1;
        @(negedge clk_i);
    endtask

    task automatic quiet();
        start_i = 0; clr_i = 0; stall_i = 0; flush_i = 0; jump_i = 0; branch_i = 0; retire_i = 0;
        bus.req_i = 0; bus.sel_i = 0; bus2.req_i = 0; bus2.sel_i = 0;
    endtask

    task automatic clr_all();
        quiet(); clr_i = 1; tick(); clr_i = 0;
    endtask

    task automatic read_cnt(input logic [1:0] s, output logic a, output logic [31:0] d);
        bus.req_i = 1; bus.sel_i = s; tick();
        a = bus.ack_o; d = bus.data_o; bus.req_i = 0;
    endtask

    task automatic test_reset();
        logic a; logic [31:0] d;
        n_cmp++; if (running_o !== 1'b0) begin n_bad++; $display("FAIL reset_running: got %b want 0", running_o); end
        n_cmp++; if (halt_o !== 1'b0) begin n_bad++; $display("FAIL reset_halt: got %b want 0", halt_o); end
        n_cmp++; if (bus.ack_o !== 1'b0) begin n_bad++; $display("FAIL reset_ack: got %b want 0", bus.ack_o); end
        n_cmp++; if (bus.data_o !== 32'd0) begin n_bad++; $display("FAIL reset_data: got %0d want 0", bus.data_o); end
        start_i = 1; repeat (4) tick();
        read_cnt(2'd0, a, d);
        n_cmp++; if (a !== 1'b1 || d !== 32'd3) begin n_bad++; $display("FAIL pre_reset_read: got ack %b data %0d want 1/3", a, d); end
        bus.req_i = 1; bus.sel_i = 0;
        @(posedge clk_i); #2;
        rst_i = 0; #1;
        model_reset();
        n_cmp++; if (bus.ack_o !== 1'b0) begin n_bad++; $display("FAIL midread_reset_ack: got %b want 0", bus.ack_o); end
        n_cmp++; if (bus.data_o !== 32'd0) begin n_bad++; $display("FAIL midread_reset_data: got %0d want 0", bus.data_o); end
        n_cmp++; if (running_o !== 1'b0) begin n_bad++; $display("FAIL midread_reset_running: got %b want 0", running_o); end
        quiet();
        @(negedge clk_i); rst_i = 1;
        read_cnt(2'd0, a, d);
        n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL post_reset_cycle: got %0d want 0", d); end
    endtask

    task automatic test_cycle_limit();
        logic a; logic [31:0] d;
        clr_all(); start_i = 1;
        for (int i = 1; i <= 35; i++) begin
            tick();
            n_cmp++; if (halt_o !== (i >= 31)) begin n_bad++; $display("FAIL limit_halt@%0d: got %b want %b", i, halt_o, i >= 31); end
            n_cmp++; if (running_o !== (i < 31)) begin n_bad++; $display("FAIL limit_running@%0d: got %b want %b", i, running_o, i < 31); end
        end
        read_cnt(2'd0, a, d);
        n_cmp++; if (a !== 1'b1 || d !== 32'd30) begin n_bad++; $display("FAIL limit_cycle: got ack %b data %0d want 1/30", a, d); end
        repeat (3) tick();
        read_cnt(2'd0, a, d);
        n_cmp++; if (d !== 32'd30 || halt_o !== 1'b1) begin n_bad++; $display("FAIL limit_hold: got data %0d halt %b want 30/1", d, halt_o); end
        start_i = 0;
    endtask

    task automatic test_stall();
        logic a; logic [31:0] d;
        clr_all(); start_i = 1; tick();
        stall_i = 1; repeat (3) tick();
        branch_i = 1; repeat (2) tick();
        stall_i = 0; branch_i = 0; start_i = 0; tick();
        read_cnt(2'd1, a, d);
        n_cmp++; if (a !== 1'b1 || d !== 32'd3) begin n_bad++; $display("FAIL stall_count: got ack %b data %0d want 1/3", a, d); end
    endtask

    task automatic test_flush_retire();
        logic a; logic [31:0] d;
        clr_all(); start_i = 1; tick();
        flush_i = 1; retire_i = 1; repeat (4) tick();
        flush_i = 0; repeat (6) tick();
        retire_i = 0; start_i = 0; tick();
        read_cnt(2'd2, a, d);
        n_cmp++; if (d !== 32'd4) begin n_bad++; $display("FAIL flush_count: got %0d want 4", d); end
        read_cnt(2'd3, a, d);
        n_cmp++; if (d !== 32'd10) begin n_bad++; $display("FAIL retire_count: got %0d want 10", d); end
        read_cnt(2'd1, a, d);
        n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL stall_zero: got %0d want 0", d); end
    endtask

    task automatic test_resume();
        logic a; logic [31:0] d;
        clr_all();
        start_i = 1; repeat (10) tick();
        start_i = 0; repeat (5) tick();
        start_i = 1; repeat (7) tick();
        start_i = 0; tick();
        read_cnt(2'd0, a, d);
        n_cmp++; if (d !== 32'd17) begin n_bad++; $display("FAIL resume_cycle: got %0d want 17", d); end
        n_cmp++; if (halt_o !== 1'b0) begin n_bad++; $display("FAIL resume_halt: got %b want 0", halt_o); end
    endtask

    task automatic test_clr_read();
        logic a; logic [31:0] d;
        clr_all(); start_i = 1; tick();
        retire_i = 1; repeat (10) tick();
        retire_i = 0; start_i = 0; tick();
        clr_i = 1; bus.req_i = 1; bus.sel_i = 3; tick();
        clr_i = 0; bus.req_i = 0;
        n_cmp++; if (bus.ack_o !== 1'b1 || bus.data_o !== 32'd10) begin n_bad++; $display("FAIL clr_read: got ack %b data %0d want 1/10", bus.ack_o, bus.data_o); end
        tick();
        n_cmp++; if (bus.ack_o !== 1'b0 || bus.data_o !== 32'd10) begin n_bad++; $display("FAIL data_hold: got ack %b data %0d want 0/10", bus.ack_o, bus.data_o); end
        read_cnt(2'd3, a, d);
        n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL after_clr: got %0d want 0", d); end
    endtask

    task automatic test_sat();
        logic [3:0] exp;
`ifdef PIPE_MONITOR_SAT_EN
        exp = 4'd15;
`else
        exp = 4'd4;
`endif
        clr_all(); start_i = 1; tick();
        retire_i = 1; repeat (20) tick();
        retire_i = 0; start_i = 0; tick();
        bus2.req_i = 1; bus2.sel_i = 3; tick(); bus2.req_i = 0;
        n_cmp++; if (bus2.ack_o !== 1'b1 || bus2.data_o !== exp) begin n_bad++; $display("FAIL narrow_retire: got ack %b data %0d want 1/%0d", bus2.ack_o, bus2.data_o, exp); end
        n_cmp++; if (halt2 !== 1'b0) begin n_bad++; $display("FAIL narrow_nolimit_halt: got %b want 0", halt2); end
    endtask

    task automatic test_random();
        clr_all();
        for (int i = 0; i < 500; i++) begin
            clr_i    = ($urandom % 60) == 0;
            start_i  = ($urandom % 8) != 0;
            stall_i  = $urandom % 2;
            jump_i   = ($urandom % 4) == 0;
            branch_i = ($urandom % 4) == 0;
            flush_i  = $urandom % 2;
            retire_i = $urandom % 2;
            bus.req_i = $urandom % 2;
            bus.sel_i = 2'($urandom % 4);
            tick();
            n_cmp++; if (running_o !== m_run) begin n_bad++; $display("FAIL rnd_running@%0d: got %b want %b", i, running_o, m_run); end
            n_cmp++; if (halt_o !== m_halt) begin n_bad++; $display("FAIL rnd_halt@%0d: got %b want %b", i, halt_o, m_halt); end
            n_cmp++; if (bus.ack_o !== m_ack) begin n_bad++; $display("FAIL rnd_ack@%0d: got %b want %b", i, bus.ack_o, m_ack); end
            n_cmp++; if (bus.data_o !== 32'(m_data)) begin n_bad++; $display("FAIL rnd_data@%0d: got %0d want %0d", i, bus.data_o, m_data); end
        end
        quiet();
    endtask

    initial begin
        rst_i = 0; quiet(); model_reset();
        repeat (2) @(negedge clk_i);
        #1;
        rst_i = 1;
        @(negedge clk_i);
        test_reset();
        test_cycle_limit();
        test_stall();
        test_flush_retire();
        test_resume();
        test_clr_read();
        test_sat();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
